mmio_controller: RTL and testbench
==================================

MMIO_CONTROLLER -- requirements
Module: mmio_controller

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 16, data width.
- ADDR_W, default 16, address width.
- KB_DEPTH, default 8, keyboard FIFO depth (power of 2, at least 2).
- SRAM_WAIT, default 2, SRAM access wait cycles (at least 1).
- IO_BASE, default 'hFE00, base of the I/O register window.
REQ-002 Clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 MIO_EN  in  1  CPU access request.
REQ-005 R_W  in  1  1 = write, 0 = read.
REQ-006 Address  in  ADDR_W  access address.
REQ-007 Data_FromCPU  in  DATA_W  write data.
REQ-008 Data_FromSRAM  in  DATA_W  SRAM read data.
REQ-009 Data_FromKeyboard  in  DATA_W  key code.
REQ-010 Keypress  in  1  key strobe, one cycle per key.
REQ-011 Video_Ready  in  1  display accepts character.
REQ-012 Mem_CE, Mem_OE, Mem_WE, Mem_LB, Mem_UB  out  1 each  SRAM controls, active-high.
REQ-013 Data_ToSRAM  out  DATA_W  SRAM write data.
REQ-014 Data_ToCPU  out  DATA_W  read data.
REQ-015 Mem_Ready  out  1  access-complete pulse.
REQ-016 Data_ToVideo  out  DATA_W  character to display.
REQ-017 Video_Valid  out  1  character pending.
REQ-018 KB_Count  out  $clog2(KB_DEPTH)+1  FIFO occupancy.

Function
REQ-019 Register map SHALL be: IO_BASE+0 KBSR (read/write), +2 KBDR (read pops the FIFO), +4 DSR (read/write), +6 DDR (write only); every other address is SRAM.
REQ-020 The FSM SHALL have states IDLE, IO, SRAM, DONE, and SHALL accept a request only in IDLE with MIO_EN=1, latching Address, R_W and Data_FromCPU at acceptance.
REQ-021 From IDLE, an I/O address SHALL go to IO and an SRAM address SHALL go to SRAM with the wait counter loaded to SRAM_WAIT-1.
REQ-022 In SRAM:
- Mem_OE SHALL be high for a read and Mem_WE high for a write.
- The counter SHALL decrement each cycle.
- At zero, read data SHALL be registered into Data_ToCPU and the FSM SHALL go to DONE.
REQ-023 IO SHALL last one cycle, except a DDR write while Video_Valid=1, which stalls in IO until Video_Valid is 0.
REQ-024 DONE SHALL assert Mem_Ready for exactly one cycle, hold Data_ToCPU valid, and return to IDLE; SRAM latency is SRAM_WAIT+2 cycles and unstalled I/O latency is 3 cycles, acceptance edge to Mem_Ready.
REQ-025 Data_ToSRAM SHALL equal latched write data; Mem_CE, Mem_LB and Mem_UB SHALL be constant 1.
REQ-026 Keypress=1 with Data_FromKeyboard nonzero SHALL push the FIFO; zero codes SHALL be ignored.
REQ-027 A push when full SHALL be dropped and SHALL set sticky overflow flag KBSR[14].
REQ-028 KBSR read SHALL return {~empty, overflow, zeros}; any KBSR write SHALL clear overflow.
REQ-029 KBDR read SHALL return the FIFO head and pop it in the IO cycle; when empty it SHALL return 0 with no pop.
REQ-030 Simultaneous push and pop SHALL both occur: count is unchanged when not empty; when empty the push is kept; when full no overflow is set.
REQ-031 Pointers SHALL wrap modulo KB_DEPTH.
REQ-032 A DDR write SHALL load Data_ToVideo and set Video_Valid; Video_Valid SHALL clear on the edge where Video_Valid and Video_Ready are both 1.
REQ-033 DSR read SHALL return {~Video_Valid, stored[DATA_W-2:0]}; DSR write SHALL store bits DATA_W-2:0 only.

Reset
REQ-034 Reset SHALL, on the next edge and even mid-access:
- return the FSM to IDLE and drop Mem_OE, Mem_WE and Mem_Ready to 0;
- empty the FIFO so KB_Count=0;
- clear overflow, DSR, Data_ToCPU, Data_ToVideo and Video_Valid to 0.
REQ-035 A request aborted by Reset SHALL never produce Mem_Ready.

Verification
REQ-036 SRAM_WAIT=2, read 'h3000 with Data_FromSRAM='hBEEF -> Mem_OE high for 2 cycles, Mem_Ready pulses 4 cycles after acceptance, Data_ToCPU='hBEEF.
REQ-037 Push 'h0041 and 'h0042, then read KBSR and KBDR twice -> KBSR='h8000; KBDR reads give 'h0041 then 'h0042; a third KBDR read gives 0; KB_Count goes 2,1,0.
REQ-038 KB_DEPTH=8, push 9 keys -> KB_Count=8, KBSR='hC000; write KBSR -> KBSR='h8000.
REQ-039 With the FIFO full, a push coincides with a KBDR pop -> KB_Count stays 8 and overflow stays 0.
REQ-040 DDR write 'h0058 with Video_Ready=0, then a second DDR write -> the second stalls with DSR[15]=0; raising Video_Ready completes it, Data_ToVideo becomes the second value, and Mem_Ready follows.
REQ-041 Reset during the SRAM state of a write -> Mem_WE drops next cycle, no Mem_Ready, all outputs at reset values.

Source files
------------

// File: rtl/mmio_controller.sv
// rtl/mmio_controller.sv - CPU memory-mapped I/O controller: SRAM sequencing, keyboard FIFO, display register.
// Requests are latched in IDLE and completed with a one-cycle Mem_Ready pulse from DONE.
module mmio_controller #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                KB_DEPTH  = 8,
  parameter int                SRAM_WAIT = 2,
  parameter logic [ADDR_W-1:0] IO_BASE   = 'hFE00
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        MIO_EN,
  input  logic                        R_W,
  input  logic [ADDR_W-1:0]           Address,
  input  logic [DATA_W-1:0]           Data_FromCPU,
  input  logic [DATA_W-1:0]           Data_FromSRAM,
  input  logic [DATA_W-1:0]           Data_FromKeyboard,
  input  logic                        Keypress,
  input  logic                        Video_Ready,
  output logic                        Mem_CE,
  output logic                        Mem_OE,
  output logic                        Mem_WE,
  output logic                        Mem_LB,
  output logic                        Mem_UB,
  output logic [DATA_W-1:0]           Data_ToSRAM,
  output logic [DATA_W-1:0]           Data_ToCPU,
  output logic                        Mem_Ready,
  output logic [DATA_W-1:0]           Data_ToVideo,
  output logic                        Video_Valid,
  output logic [$clog2(KB_DEPTH):0]   KB_Count
);

  localparam int PW = $clog2(KB_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(SRAM_WAIT + 1);

  localparam logic [ADDR_W-1:0] KBSR_A = IO_BASE;
  localparam logic [ADDR_W-1:0] KBDR_A = IO_BASE + ADDR_W'(2);
  localparam logic [ADDR_W-1:0] DSR_A  = IO_BASE + ADDR_W'(4);
  localparam logic [ADDR_W-1:0] DDR_A  = IO_BASE + ADDR_W'(6);

  typedef enum logic [1:0] {S_IDLE, S_IO, S_SRAM, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                oe_q, oe_d;
  logic                we_q, we_d;
  logic                ready_q, ready_d;
  logic [PW-1:0]       kb_wr_q, kb_wr_d;
  logic [PW-1:0]       kb_rd_q, kb_rd_d;
  logic [CW-1:0]       kb_cnt_q, kb_cnt_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   dsr_q, dsr_d;
  logic [DATA_W-1:0]   vid_data_q, vid_data_d;
  logic                vid_valid_q, vid_valid_d;
  logic [DATA_W-1:0]   kb_mem_q [KB_DEPTH];

  logic io_hit;
  logic is_kbsr, is_kbdr, is_dsr, is_ddr;
  logic kb_empty, kb_full, kb_push, kb_pop, kb_push_ok, ddr_stall;
  logic [DATA_W-1:0] kb_head;

  assign io_hit  = (Address == KBSR_A) || (Address == KBDR_A) ||
                   (Address == DSR_A)  || (Address == DDR_A);
  assign is_kbsr = (addr_q == KBSR_A);
  assign is_kbdr = (addr_q == KBDR_A);
  assign is_dsr  = (addr_q == DSR_A);
  assign is_ddr  = (addr_q == DDR_A);

  assign kb_empty   = (kb_cnt_q == '0);
  assign kb_full    = (kb_cnt_q == CW'(KB_DEPTH));
  assign kb_head    = kb_mem_q[kb_rd_q];
  assign kb_push    = Keypress && (Data_FromKeyboard != '0);
  assign kb_pop     = (state_q == S_IO) && !rw_q && is_kbdr && !kb_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign kb_push_ok = kb_push && (!kb_full || kb_pop);
  assign ddr_stall  = (state_q == S_IO) && rw_q && is_ddr && vid_valid_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    wait_d      = wait_q;
    rdata_d     = rdata_q;
    ovf_d       = ovf_q;
    dsr_d       = dsr_q;
    vid_data_d  = vid_data_q;
    vid_valid_d = vid_valid_q;
    kb_wr_d     = kb_wr_q;
    kb_rd_d     = kb_rd_q;

    if (vid_valid_q && Video_Ready) begin
      vid_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (MIO_EN) begin
          addr_d  = Address;
          rw_d    = R_W;
          wdata_d = Data_FromCPU;
          if (io_hit) begin
            state_d = S_IO;
          end else begin
            state_d = S_SRAM;
            wait_d  = WW'(SRAM_WAIT - 1);
          end
        end
      end
      S_IO: begin
        if (!ddr_stall) begin
          state_d = S_DONE;
          if (rw_q) begin
            if (is_kbsr) ovf_d = 1'b0;
            if (is_dsr)  dsr_d = {1'b0, wdata_q[DATA_W-2:0]};
            if (is_ddr) begin
              vid_data_d  = wdata_q;
              vid_valid_d = 1'b1;
            end
          end else if (is_kbsr) begin
            rdata_d = {~kb_empty, ovf_q, {(DATA_W-2){1'b0}}};
          end else if (is_kbdr) begin
            rdata_d = kb_empty ? '0 : kb_head;
          end else if (is_dsr) begin
            rdata_d = {~vid_valid_q, dsr_q[DATA_W-2:0]};
          end else begin
            rdata_d = '0;
          end
        end
      end
      S_SRAM: begin
        if (wait_q == '0) begin
          state_d = S_DONE;
          if (!rw_q) rdata_d = Data_FromSRAM;
        end else begin
          wait_d = wait_q - WW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A dropped key is recorded after any clear so the loss is never hidden.
    if (kb_push && kb_full && !kb_pop) begin
      ovf_d = 1'b1;
    end
    if (kb_push_ok) kb_wr_d = kb_wr_q + PW'(1);
    if (kb_pop)     kb_rd_d = kb_rd_q + PW'(1);
    kb_cnt_d = kb_cnt_q + CW'(kb_push_ok) - CW'(kb_pop);

    oe_d    = (state_d == S_SRAM) && !rw_d;
    we_d    = (state_d == S_SRAM) && rw_d;
    ready_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      wait_q      <= '0;
      rdata_q     <= '0;
      oe_q        <= 1'b0;
      we_q        <= 1'b0;
      ready_q     <= 1'b0;
      kb_wr_q     <= '0;
      kb_rd_q     <= '0;
      kb_cnt_q    <= '0;
      ovf_q       <= 1'b0;
      dsr_q       <= '0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      wait_q      <= wait_d;
      rdata_q     <= rdata_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      ready_q     <= ready_d;
      kb_wr_q     <= kb_wr_d;
      kb_rd_q     <= kb_rd_d;
      kb_cnt_q    <= kb_cnt_d;
      ovf_q       <= ovf_d;
      dsr_q       <= dsr_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && kb_push_ok) begin
      kb_mem_q[kb_wr_q] <= Data_FromKeyboard;
    end
  end

  assign Mem_CE       = 1'b1;
  assign Mem_LB       = 1'b1;
  assign Mem_UB       = 1'b1;
  assign Mem_OE       = oe_q;
  assign Mem_WE       = we_q;
  assign Mem_Ready    = ready_q;
  assign Data_ToSRAM  = wdata_q;
  assign Data_ToCPU   = rdata_q;
  assign Data_ToVideo = vid_data_q;
  assign Video_Valid  = vid_valid_q;
  assign KB_Count     = kb_cnt_q;

endmodule

// File: tb/tb_mmio_controller.sv
// tb/tb_mmio_controller.sv - scoreboard bench for mmio_controller with a queue-based reference model.
module tb_mmio_controller;

  localparam int          SW  = 2;
  localparam int          KD  = 8;
  localparam logic [15:0] IOB = 16'hFE00;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        MIO_EN = 1'b0;
  logic        R_W = 1'b0;
  logic [15:0] Address = '0;
  logic [15:0] Data_FromCPU = '0;
  logic [15:0] Data_FromSRAM = '0;
  logic [15:0] Data_FromKeyboard = '0;
  logic        Keypress = 1'b0;
  logic        Video_Ready = 1'b0;
  logic        Mem_CE, Mem_OE, Mem_WE, Mem_LB, Mem_UB, Mem_Ready, Video_Valid;
  logic [15:0] Data_ToSRAM, Data_ToCPU, Data_ToVideo;
  logic [3:0]  KB_Count;

  mmio_controller #(
    .DATA_W(16), .ADDR_W(16), .KB_DEPTH(KD), .SRAM_WAIT(SW), .IO_BASE(IOB)
  ) dut (
    .Clk(Clk), .Reset(Reset), .MIO_EN(MIO_EN), .R_W(R_W), .Address(Address),
    .Data_FromCPU(Data_FromCPU), .Data_FromSRAM(Data_FromSRAM),
    .Data_FromKeyboard(Data_FromKeyboard), .Keypress(Keypress), .Video_Ready(Video_Ready),
    .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Mem_LB(Mem_LB), .Mem_UB(Mem_UB),
    .Data_ToSRAM(Data_ToSRAM), .Data_ToCPU(Data_ToCPU), .Mem_Ready(Mem_Ready),
    .Data_ToVideo(Data_ToVideo), .Video_Valid(Video_Valid), .KB_Count(KB_Count)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    bit          chk_data;
    bit          chk_tosram;
    logic [15:0] wdata;
    int          req_cyc;
    int          lat;
    int          oe;
    int          we;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int oe_cnt = 0;
  int we_cnt = 0;

  // Reference model state
  logic [15:0] kb_q[$];
  bit          m_ovf = 1'b0;
  logic [15:0] m_dsr = '0;
  bit          m_vpend = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (Mem_OE) oe_cnt++;
    if (Mem_WE) we_cnt++;
    if (Mem_Ready) begin
      if (sb.size() == 0) begin
        chk("spurious_mem_ready", 32'(Mem_Ready), 32'd0);
      end else begin
        me = sb.pop_front();
        if (me.chk_data)   chk("data_to_cpu", 32'(Data_ToCPU), 32'(me.data));
        if (me.lat != 0)   chk("latency", 32'(cyc - me.req_cyc + 1), 32'(me.lat));
        chk("oe_cycles", 32'(oe_cnt), 32'(me.oe));
        chk("we_cycles", 32'(we_cnt), 32'(me.we));
        if (me.chk_tosram) chk("data_to_sram", 32'(Data_ToSRAM), 32'(me.wdata));
      end
      oe_cnt = 0;
      we_cnt = 0;
      done_cnt++;
    end
  end

  function automatic bit is_io(input logic [15:0] a);
    return (a == IOB) || (a == IOB + 16'd2) || (a == IOB + 16'd4) || (a == IOB + 16'd6);
  endfunction

  task automatic model_reset();
    kb_q.delete();
    m_ovf = 1'b0;
    m_dsr = '0;
    m_vpend = 1'b0;
  endtask

  task automatic apply_reset();
    MIO_EN = 1'b0;
    Keypress = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    oe_cnt = 0;
    we_cnt = 0;
  endtask

  // Called at a negedge; the following posedge is the acceptance edge.
  task automatic issue(input bit rw, input logic [15:0] a, input logic [15:0] wd,
                       input logic [15:0] sd, input bit chk_lat, input bit track);
    exp_t e;
    logic [15:0] off;
    e.chk_data   = !rw;
    e.chk_tosram = !is_io(a) && rw;
    e.wdata      = wd;
    e.lat        = chk_lat ? (is_io(a) ? 3 : SW + 2) : 0;
    e.oe         = (!is_io(a) && !rw) ? SW : 0;
    e.we         = (!is_io(a) && rw) ? SW : 0;
    e.data       = '0;
    if (!is_io(a)) begin
      e.data = sd;
    end else begin
      off = a - IOB;
      case (off)
        16'd0: if (rw) m_ovf = 1'b0;
               else e.data = {kb_q.size() != 0, m_ovf, 14'b0};
        16'd2: if (!rw && kb_q.size() != 0) e.data = kb_q.pop_front();
        16'd4: if (rw) m_dsr = wd & 16'h7FFF;
               else e.data = {~m_vpend, m_dsr[14:0]};
        default: if (rw) m_vpend = 1'b1;
      endcase
    end
    Address = a;
    R_W = rw;
    Data_FromCPU = wd;
    Data_FromSRAM = sd;
    MIO_EN = 1'b1;
    e.req_cyc = cyc;
    if (track) sb.push_back(e);
    @(negedge Clk);
    MIO_EN = 1'b0;
  endtask

  task automatic wait_done(input int tgt);
    int t = 0;
    while (done_cnt < tgt && t < 60) begin
      @(negedge Clk);
      t++;
    end
    if (done_cnt < tgt) begin
      chk("access_timeout", 32'(done_cnt), 32'(tgt));
      sb.delete();
      apply_reset();
    end
    @(negedge Clk);
  endtask

  task automatic do_acc(input bit rw, input logic [15:0] a, input logic [15:0] wd, input logic [15:0] sd);
    int tgt = done_cnt + 1;
    issue(rw, a, wd, sd, 1'b1, 1'b1);
    wait_done(tgt);
  endtask

  task automatic keypress(input logic [15:0] code);
    Keypress = 1'b1;
    Data_FromKeyboard = code;
    @(negedge Clk);
    Keypress = 1'b0;
    if (code != 0) begin
      if (kb_q.size() < KD) kb_q.push_back(code);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic vready_pulse();
    Video_Ready = 1'b1;
    @(negedge Clk);
    Video_Ready = 1'b0;
    m_vpend = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt;
    logic [15:0] a;
    logic [15:0] d;
    int r;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    model_reset();

    chk("rst_kb_count", 32'(KB_Count), 32'd0);
    chk("rst_video_valid", 32'(Video_Valid), 32'd0);
    chk("rst_mem_ready", 32'(Mem_Ready), 32'd0);
    chk("rst_mem_oe", 32'(Mem_OE), 32'd0);
    chk("rst_mem_we", 32'(Mem_WE), 32'd0);
    chk("rst_data_to_cpu", 32'(Data_ToCPU), 32'd0);
    chk("const_ce_lb_ub", 32'({Mem_CE, Mem_LB, Mem_UB}), 32'h7);

    do_acc(1'b0, 16'h3000, 16'h0000, 16'hBEEF);
    chk("sram_read_beef", 32'(Data_ToCPU), 32'hBEEF);
    do_acc(1'b1, 16'h3002, 16'h5A5A, 16'h0000);

    keypress(16'h0041);
    keypress(16'h0042);
    chk("kb_count_2", 32'(KB_Count), 32'd2);
    do_acc(1'b0, IOB, 16'h0, 16'h0);
    do_acc(1'b0, IOB + 16'd2, 16'h0, 16'h0);
    chk("kb_count_1", 32'(KB_Count), 32'd1);
    do_acc(1'b0, IOB + 16'd2, 16'h0, 16'h0);
    chk("kb_count_0", 32'(KB_Count), 32'd0);
    do_acc(1'b0, IOB + 16'd2, 16'h0, 16'h0);
    keypress(16'h0000);
    chk("kb_zero_ignored", 32'(KB_Count), 32'd0);

    for (int i = 0; i < 9; i++) keypress(16'(16'h0061 + i));
    chk("kb_full_count", 32'(KB_Count), 32'd8);
    do_acc(1'b0, IOB, 16'h0, 16'h0);
    do_acc(1'b1, IOB, 16'hFFFF, 16'h0);
    do_acc(1'b0, IOB, 16'h0, 16'h0);

    tgt = done_cnt + 1;
    issue(1'b0, IOB + 16'd2, 16'h0, 16'h0, 1'b1, 1'b1);
    Keypress = 1'b1;
    Data_FromKeyboard = 16'h0077;
    @(negedge Clk);
    Keypress = 1'b0;
    kb_q.push_back(16'h0077);
    wait_done(tgt);
    chk("full_push_pop_count", 32'(KB_Count), 32'd8);
    do_acc(1'b0, IOB, 16'h0, 16'h0);

    Video_Ready = 1'b0;
    do_acc(1'b1, IOB + 16'd6, 16'h0058, 16'h0);
    do_acc(1'b0, IOB + 16'd4, 16'h0, 16'h0);
    tgt = done_cnt + 1;
    issue(1'b1, IOB + 16'd6, 16'h0123, 16'h0, 1'b0, 1'b1);
    repeat (5) @(negedge Clk);
    chk("ddr_stall_no_ready", 32'(done_cnt), 32'(tgt - 1));
    chk("ddr_stall_hold_data", 32'(Data_ToVideo), 32'h0058);
    chk("ddr_stall_valid", 32'(Video_Valid), 32'd1);
    Video_Ready = 1'b1;
    @(negedge Clk);
    Video_Ready = 1'b0;
    wait_done(tgt);
    chk("ddr_second_data", 32'(Data_ToVideo), 32'h0123);
    chk("ddr_second_valid", 32'(Video_Valid), 32'd1);
    do_acc(1'b0, IOB + 16'd4, 16'h0, 16'h0);
    vready_pulse();
    chk("video_cleared", 32'(Video_Valid), 32'd0);

    for (int it = 0; it < 80; it++) begin
      r = int'($urandom_range(0, 9));
      d = 16'($urandom);
      case (r)
        0: begin
          a = ($urandom_range(0, 3) == 0) ? (IOB + 16'(1 + 2 * $urandom_range(0, 3))) : 16'($urandom_range(0, 16'hEFFF));
          do_acc(1'b0, a, 16'h0, d);
        end
        1: do_acc(1'b1, 16'($urandom_range(0, 16'hEFFF)), d, 16'h0);
        2, 3: keypress(($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 255)));
        4: do_acc(1'b0, IOB + 16'd2, 16'h0, 16'h0);
        5: do_acc(1'b0, IOB, 16'h0, 16'h0);
        6: do_acc(1'b1, IOB, d, 16'h0);
        7: do_acc($urandom_range(0, 1) == 1, IOB + 16'd4, d, 16'h0);
        8: if (!m_vpend) do_acc(1'b1, IOB + 16'd6, d, 16'h0);
           else vready_pulse();
        default: if ($urandom_range(0, 1) == 1) vready_pulse();
                 else do_acc(1'b0, IOB + 16'd6, 16'h0, 16'h0);
      endcase
      chk("rand_kb_count", 32'(KB_Count), 32'(kb_q.size()));
      chk("rand_video_valid", 32'(Video_Valid), 32'(m_vpend));
    end

    for (int i = 0; i < 9; i++) keypress(16'(16'h0030 + i));
    if (!m_vpend) do_acc(1'b1, IOB + 16'd6, 16'h00AA, 16'h0);
    do_acc(1'b0, 16'h0100, 16'h0, 16'h1357);
    issue(1'b1, 16'h1234, 16'hAAAA, 16'h0, 1'b0, 1'b0);
    chk("abort_we_high", 32'(Mem_WE), 32'd1);
    chk("abort_to_sram", 32'(Data_ToSRAM), 32'hAAAA);
    tgt = done_cnt;
    apply_reset();
    chk("abort_we_low", 32'(Mem_WE), 32'd0);
    chk("abort_oe_low", 32'(Mem_OE), 32'd0);
    chk("abort_ready_low", 32'(Mem_Ready), 32'd0);
    chk("abort_kb_count", 32'(KB_Count), 32'd0);
    chk("abort_video_valid", 32'(Video_Valid), 32'd0);
    chk("abort_video_data", 32'(Data_ToVideo), 32'd0);
    chk("abort_data_to_cpu", 32'(Data_ToCPU), 32'd0);
    repeat (6) @(negedge Clk);
    chk("abort_no_ready", 32'(done_cnt), 32'(tgt));
    do_acc(1'b0, IOB, 16'h0, 16'h0);
    do_acc(1'b0, IOB + 16'd4, 16'h0, 16'h0);
    do_acc(1'b0, 16'h2222, 16'h0, 16'hC0DE);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
